// File: rtl/l1_refill_arbiter.sv
// Shares the single memory port between L1 I-cache and D-cache misses: one 4-beat refill or one write per grant.
// Optional build macro ARB_ROUND_ROBIN_EN selects alternating priority instead of D-priority with starvation guard.
module l1_refill_arbiter #(
  parameter int unsigned BEATS        = 4,
  parameter int unsigned STARVE_LIMIT = 3
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  input  logic        d_req,
  input  logic        d_write,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_wstrb,
  output logic        i_rvalid,
  output logic        d_rvalid,
  output logic [31:0] i_rdata,
  output logic [31:0] d_rdata,
  output logic        i_done,
  output logic        d_done,
  output logic        mem_req,
  output logic        mem_write,
  output logic [31:0] mem_addr,
  output logic [1:0]  mem_len,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  input  logic        mem_bdone
);

  localparam int unsigned AW = 32;
  localparam int unsigned LW = 2;
`ifndef ARB_ROUND_ROBIN_EN
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
`endif

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_ISSUE = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_WRESP = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic OWN_I = 1'b0;
  localparam logic OWN_D = 1'b1;

  localparam logic [AW-1:0] LINE_MASK = 32'hFFFF_FFF0;

  logic [2:0]    state, state_d;
  logic          owner, owner_d;
  logic [LW-1:0] beat, beat_d;
  logic          skip, skip_d;
  logic          i_req_q, d_req_q;
  logic          win_i, win_d;
  logic          mem_req_d, mem_write_d, i_done_d, d_done_d;
  logic [AW-1:0] mem_addr_d, mem_wdata_d;
  logic [LW-1:0] mem_len_d;
  logic [3:0]    mem_wstrb_d;
  logic          beat_hit;
`ifndef ARB_ROUND_ROBIN_EN
  logic [CW-1:0] starve_cnt, starve_cnt_d;
`endif

  // Read beats bypass straight to the owning cache; nothing leaks outside DATA.
  assign beat_hit = (state == S_DATA) && mem_rvalid;
  assign i_rvalid = beat_hit && (owner == OWN_I);
  assign d_rvalid = beat_hit && (owner == OWN_D);
  assign i_rdata  = i_rvalid ? mem_rdata : '0;
  assign d_rdata  = d_rvalid ? mem_rdata : '0;

  // State register and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      owner     <= OWN_I;
      beat      <= '0;
      skip      <= 1'b0;
      i_req_q   <= 1'b0;
      d_req_q   <= 1'b0;
      mem_req   <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_len   <= '0;
      mem_wdata <= '0;
      mem_wstrb <= '0;
      i_done    <= 1'b0;
      d_done    <= 1'b0;
`ifndef ARB_ROUND_ROBIN_EN
      starve_cnt <= '0;
`endif
    end else begin
      state     <= state_d;
      owner     <= owner_d;
      beat      <= beat_d;
      skip      <= skip_d;
      i_req_q   <= i_req;
      d_req_q   <= d_req;
      mem_req   <= mem_req_d;
      mem_write <= mem_write_d;
      mem_addr  <= mem_addr_d;
      mem_len   <= mem_len_d;
      mem_wdata <= mem_wdata_d;
      mem_wstrb <= mem_wstrb_d;
      i_done    <= i_done_d;
      d_done    <= d_done_d;
`ifndef ARB_ROUND_ROBIN_EN
      starve_cnt <= starve_cnt_d;
`endif
    end
  end

  // Next-state, arbitration and output decode.
  always_comb begin
    state_d     = state;
    owner_d     = owner;
    beat_d      = beat;
    skip_d      = 1'b0;
    win_i       = 1'b0;
    win_d       = 1'b0;
    mem_req_d   = mem_req;
    mem_write_d = mem_write;
    mem_addr_d  = mem_addr;
    mem_len_d   = mem_len;
    mem_wdata_d = mem_wdata;
    mem_wstrb_d = mem_wstrb;
    i_done_d    = 1'b0;
    d_done_d    = 1'b0;
`ifndef ARB_ROUND_ROBIN_EN
    starve_cnt_d = starve_cnt;
`endif

    case (state)
      S_IDLE: begin
        // The cycle right after DONE still sees the finished owner's req; skip it.
        if (!skip) begin
`ifdef ARB_ROUND_ROBIN_EN
          win_d = d_req_q && (!i_req_q || (owner == OWN_I));
`else
          win_d = d_req_q && !(i_req_q && (starve_cnt == CW'(STARVE_LIMIT)));
`endif
          win_i = i_req_q && !win_d;
        end
        if (win_d) begin
          owner_d     = OWN_D;
          state_d     = S_ISSUE;
          mem_req_d   = 1'b1;
          mem_write_d = d_write;
          mem_addr_d  = d_write ? d_addr : (d_addr & LINE_MASK);
          mem_len_d   = d_write ? '0 : LW'(BEATS - 1);
          mem_wdata_d = d_wdata;
          mem_wstrb_d = d_wstrb;
        end else if (win_i) begin
          owner_d     = OWN_I;
          state_d     = S_ISSUE;
          mem_req_d   = 1'b1;
          mem_write_d = 1'b0;
          mem_addr_d  = i_addr & LINE_MASK;
          mem_len_d   = LW'(BEATS - 1);
          mem_wdata_d = '0;
          mem_wstrb_d = '0;
        end
`ifndef ARB_ROUND_ROBIN_EN
        if (win_i || !i_req_q) begin
          starve_cnt_d = '0;
        end else if (win_d && (starve_cnt != CW'(STARVE_LIMIT))) begin
          starve_cnt_d = starve_cnt + CW'(1);
        end
`endif
      end
      S_ISSUE: begin
        beat_d = '0;
        if (mem_gnt) begin
          mem_req_d = 1'b0;
          state_d   = mem_write ? S_WRESP : S_DATA;
        end
      end
      S_DATA: begin
        if (mem_rvalid) begin
          beat_d = beat + LW'(1);
          if (beat == LW'(BEATS - 1)) begin
            state_d  = S_DONE;
            i_done_d = (owner == OWN_I);
            d_done_d = (owner == OWN_D);
          end
        end
      end
      S_WRESP: begin
        if (mem_bdone) begin
          state_d  = S_DONE;
          d_done_d = (owner == OWN_D);
          i_done_d = (owner == OWN_I);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        skip_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_l1_refill_arbiter.sv
// Directed bench for l1_refill_arbiter: vector table of single transactions plus multi-cycle corner sequences.
module tb_l1_refill_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_req, d_req, d_write;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_wstrb;
  logic        i_rvalid, d_rvalid, i_done, d_done;
  logic [31:0] i_rdata, d_rdata;
  logic        mem_req, mem_write;
  logic [31:0] mem_addr, mem_wdata;
  logic [1:0]  mem_len;
  logic [3:0]  mem_wstrb;
  logic        mem_gnt, mem_rvalid, mem_bdone;
  logic [31:0] mem_rdata;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic        is_d;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] base;
    logic [31:0] exp_addr;
    logic [1:0]  exp_len;
    logic [31:0] exp_wdata;
  } vec_t;

  vec_t vecs [4];

  l1_refill_arbiter dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr),
    .d_req(d_req), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .i_rvalid(i_rvalid), .d_rvalid(d_rvalid), .i_rdata(i_rdata), .d_rdata(d_rdata),
    .i_done(i_done), .d_done(d_done),
    .mem_req(mem_req), .mem_write(mem_write), .mem_addr(mem_addr), .mem_len(mem_len),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .mem_bdone(mem_bdone)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Responds to one read: grant, four beats, then checks the owner's done pulse.
  task automatic serve(input logic [31:0] exp_addr, input logic exp_d, input logic [31:0] base);
    int n;
    n = 0;
    while (!mem_req && n < 30) begin
      step();
      n++;
    end
    if (!mem_req) begin
      chk("serve_timeout", 64'(mem_req), 64'(1));
    end else begin
      chk("serve_addr", 64'(mem_addr), 64'(exp_addr));
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      for (int k = 0; k < 4; k++) begin
        mem_rvalid = 1'b1;
        mem_rdata  = base + 32'(k);
        #1;
        chk("serve_vld", 64'({i_rvalid, d_rvalid}), exp_d ? 64'(2'b01) : 64'(2'b10));
        chk("serve_data", 64'(exp_d ? d_rdata : i_rdata), 64'(base + 32'(k)));
        step();
      end
      mem_rvalid = 1'b0;
      mem_rdata  = '0;
      chk("serve_done", 64'({i_done, d_done}), exp_d ? 64'(2'b01) : 64'(2'b10));
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_ctrl"}, 64'({i_rvalid, d_rvalid, i_done, d_done, mem_req, mem_write, mem_len, mem_wstrb}), 64'(0));
    chk({tag, "_addr"}, 64'(mem_addr), 64'(0));
    chk({tag, "_wdata"}, 64'(mem_wdata), 64'(0));
    chk({tag, "_rdata"}, {i_rdata, d_rdata}, 64'(0));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_write = 1'b0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0; mem_bdone = 1'b0;

    vecs[0] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0, 4'h0, 32'hA0, 32'h0000_1230, 2'd3, 32'h0};
    vecs[1] = '{1'b1, 1'b1, 32'h8000_0006, 32'h1122_3344, 4'b1100, 32'h0, 32'h8000_0006, 2'd0, 32'h1122_3344};
    vecs[2] = '{1'b1, 1'b0, 32'h4000_00FF, 32'h0, 4'h0, 32'hB0, 32'h4000_00F0, 2'd3, 32'h0};
    vecs[3] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 4'h0, 32'hC0, 32'hFFFF_FFF0, 2'd3, 32'h0};

    step(); step();
    chk_all_zero("reset");
    rst = 1'b1;
    step(); step();

    // Single transactions from the table.
    for (int v = 0; v < 4; v++) begin
      if (vecs[v].is_d) begin
        d_req = 1'b1; d_write = vecs[v].wr; d_addr = vecs[v].addr;
        d_wdata = vecs[v].wdata; d_wstrb = vecs[v].wstrb;
      end else begin
        i_req = 1'b1; i_addr = vecs[v].addr;
      end
      step();
      chk("lat_1cyc", 64'(mem_req), 64'(0));
      step();
      chk("lat_2cyc", 64'(mem_req), 64'(1));
      chk("vec_addr", 64'(mem_addr), 64'(vecs[v].exp_addr));
      chk("vec_len", 64'(mem_len), 64'(vecs[v].exp_len));
      chk("vec_write", 64'(mem_write), 64'(vecs[v].wr));
      chk("vec_wdata", 64'(mem_wdata), 64'(vecs[v].exp_wdata));
      chk("vec_wstrb", 64'(mem_wstrb), 64'(vecs[v].wstrb));
      mem_gnt = 1'b1;
      step();
      mem_gnt = 1'b0;
      chk("req_drop", 64'(mem_req), 64'(0));
      if (vecs[v].wr) begin
        chk("wr_wait", 64'({i_done, d_done}), 64'(0));
        mem_bdone = 1'b1;
        step();
        mem_bdone = 1'b0;
        chk("wr_done", 64'({i_done, d_done}), 64'(2'b01));
      end else begin
        for (int k = 0; k < 4; k++) begin
          mem_rvalid = 1'b1;
          mem_rdata  = vecs[v].base + 32'(k);
          #1;
          chk("beat_vld", 64'({i_rvalid, d_rvalid}), vecs[v].is_d ? 64'(2'b01) : 64'(2'b10));
          chk("beat_data", 64'(vecs[v].is_d ? d_rdata : i_rdata), 64'(vecs[v].base + 32'(k)));
          chk("beat_nodone", 64'({i_done, d_done}), 64'(0));
          step();
        end
        mem_rvalid = 1'b0;
        chk("rd_done", 64'({i_done, d_done}), vecs[v].is_d ? 64'(2'b01) : 64'(2'b10));
      end
      i_req = 1'b0; d_req = 1'b0; d_write = 1'b0; d_wdata = '0; d_wstrb = '0;
      step();
      chk("done_pulse", 64'({i_done, d_done}), 64'(0));
      step(); step();
    end

    // Simultaneous requests: D first, then I.
    i_req = 1'b1; i_addr = 32'h3000_0024;
    d_req = 1'b1; d_addr = 32'h2000_0010;
    serve(32'h2000_0010, 1'b1, 32'h20);
    d_req = 1'b0;
    serve(32'h3000_0020, 1'b0, 32'h30);
    i_req = 1'b0;
    step(); step();

    // D held continuously with I waiting: three D grants, then I is forced through.
    i_req = 1'b1; i_addr = 32'h6000_0004;
    d_req = 1'b1; d_addr = 32'h5000_0008;
    for (int g = 0; g < 3; g++) serve(32'h5000_0000, 1'b1, 32'h10 * 32'(g));
    serve(32'h6000_0000, 1'b0, 32'h40);
    i_req = 1'b0; d_req = 1'b0;
    repeat (4) step();
    chk("starve_quiet", 64'(mem_req), 64'(0));

    // Grant withheld 5 cycles: request stays stable, stray rvalid ignored.
    i_req = 1'b1; i_addr = 32'h0000_7777;
    step(); step();
    for (int c = 0; c < 5; c++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'hDEAD_BEEF;
      #1;
      chk("hold_req", 64'(mem_req), 64'(1));
      chk("hold_addr", 64'(mem_addr), 64'(32'h0000_7770));
      chk("hold_len", 64'(mem_len), 64'(3));
      chk("stray_rvalid", 64'({i_rvalid, d_rvalid}), 64'(0));
      step();
    end
    mem_rvalid = 1'b0;
    serve(32'h0000_7770, 1'b0, 32'h70);
    i_req = 1'b0;
    step(); step(); step();

    // Reset in the middle of a refill, then a fresh refill.
    i_req = 1'b1; i_addr = 32'h0000_9000;
    step(); step();
    chk("mid_req", 64'(mem_req), 64'(1));
    mem_gnt = 1'b1;
    step();
    mem_gnt = 1'b0;
    for (int k = 0; k < 2; k++) begin
      mem_rvalid = 1'b1;
      mem_rdata  = 32'h90 + 32'(k);
      step();
    end
    mem_rvalid = 1'b1;
    mem_rdata  = 32'h5555_AAAA;
    rst = 1'b0;
    i_req = 1'b0;
    #1;
    chk_all_zero("midrst");
    for (int c = 0; c < 3; c++) begin
      step();
      chk("midrst_nodone", 64'({i_done, d_done}), 64'(0));
    end
    mem_rvalid = 1'b0;
    mem_rdata  = '0;
    rst = 1'b1;
    step();
    i_req = 1'b1; i_addr = 32'h0000_ABCD;
    serve(32'h0000_ABC0, 1'b0, 32'hE0);
    i_req = 1'b0;
    step(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
